// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory access path.
package mem_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    BYTE = 2'b01,
    HALF = 2'b10
  } data_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_e;

  localparam logic [31:0] MEM_BASE_DEF = 32'h0000_1000;
  localparam logic [31:0] MEM_SIZE_DEF = 32'h0000_1000;

  function automatic logic [2:0] access_bytes(input logic [1:0] dtype);
    case (dtype)
      WORD:    access_bytes = 3'd4;
      HALF:    access_bytes = 3'd2;
      BYTE:    access_bytes = 3'd1;
      default: access_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer only moves when both requesters compete.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Grant selection and next pointer
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          gnt_o = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between two requesters: one access per grant,
// illegal requests answered with an error and never sent to memory.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_BASE      = MEM_BASE_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_SIZE      = MEM_SIZE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_valid,
  output logic                     p0_ready,
  input  logic                     p0_we,
  input  logic [1:0]               p0_type,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_rvalid,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  output logic                     p0_err,
  input  logic                     p1_valid,
  output logic                     p1_ready,
  input  logic                     p1_we,
  input  logic [1:0]               p1_type,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_rvalid,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     p1_err,
  output logic                     mem_we,
  output logic [1:0]               mem_type,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  arb_state_e               state_q;
  logic                     port_q, we_q, mem_we_q;
  logic [1:0]               type_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, p0_rdata_q, p1_rdata_q;
  logic                     p0_rvalid_q, p1_rvalid_q, p0_err_q, p1_err_q;

  logic                     arb_en, hs, sel, in_we, in_legal;
  logic [1:0]               gnt, in_type;
  logic [2:0]               in_bytes;
  logic [ADDRESS_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0]    in_wdata;
  logic [ADDRESS_WIDTH:0]   end_addr, limit;

  // Ready is withheld during reset so outputs read zero immediately.
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (arb_en),
    .req_i ({p1_valid, p0_valid}),
    .gnt_o (gnt)
  );

  assign p0_ready  = gnt[0];
  assign p1_ready  = gnt[1];
  assign hs        = |gnt;
  assign sel       = gnt[1];
  assign limit     = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

  // Payload mux and legality of the request being granted
  always_comb begin
    in_we    = sel ? p1_we    : p0_we;
    in_type  = sel ? p1_type  : p0_type;
    in_addr  = sel ? p1_addr  : p0_addr;
    in_wdata = sel ? p1_wdata : p0_wdata;
    in_bytes = access_bytes(in_type);
    end_addr = {1'b0, in_addr} + {{(ADDRESS_WIDTH-2){1'b0}}, in_bytes};
    in_legal = 1'b1;
    case (in_type)
      WORD:    if (in_addr[1:0] != 2'b00) in_legal = 1'b0; else in_legal = 1'b1;
      HALF:    if (in_addr[0] != 1'b0)    in_legal = 1'b0; else in_legal = 1'b1;
      BYTE:    in_legal = 1'b1;
      default: in_legal = 1'b0;
    endcase
    if (in_addr < MEM_BASE || end_addr > limit) in_legal = 1'b0;
    else                                        in_legal = in_legal;
  end

  // Access sequencer: IDLE -> ACCESS -> RESP, or IDLE -> RESP on error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      addr_q      <= {ADDRESS_WIDTH{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      mem_we_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= {DATA_WIDTH{1'b0}};
      p1_rdata_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            port_q  <= sel;
            we_q    <= in_we;
            type_q  <= in_type;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            if (in_legal) begin
              state_q  <= ACCESS;
              mem_we_q <= in_we;
            end else begin
              state_q     <= RESP;
              p0_rvalid_q <= !sel;
              p1_rvalid_q <= sel;
              p0_err_q    <= !sel;
              p1_err_q    <= sel;
            end
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_we_q    <= 1'b0;
          p0_rvalid_q <= !port_q;
          p1_rvalid_q <= port_q;
          if (port_q) p1_rdata_q <= we_q ? {DATA_WIDTH{1'b0}} : mem_rd;
          else        p0_rdata_q <= we_q ? {DATA_WIDTH{1'b0}} : mem_rd;
        end
        RESP: begin
          state_q     <= IDLE;
          p0_rvalid_q <= 1'b0;
          p1_rvalid_q <= 1'b0;
          p0_err_q    <= 1'b0;
          p1_err_q    <= 1'b0;
          p0_rdata_q  <= {DATA_WIDTH{1'b0}};
          p1_rdata_q  <= {DATA_WIDTH{1'b0}};
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_type  = type_q;
  assign mem_addr  = addr_q;
  assign mem_wd    = wdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
  logic [1:0]  p0_type;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rvalid, p1_err;
  logic [1:0]  p1_type;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_we;
  logic [1:0]  mem_type;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_type(p0_type),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_type(p1_type),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory model: window 0x1000..0x1FFF, sign-extending reads.
  logic [7:0]  mem [0:4095];
  logic        mem_clr_done = 1'b0;
  logic [31:0] moff;
  logic [7:0]  mb0, mb1, mb2, mb3;

  always_comb begin
    moff = mem_addr - 32'h0000_1000;
    mb0 = 8'h00; mb1 = 8'h00; mb2 = 8'h00; mb3 = 8'h00;
    if (moff < 32'd4096)          mb0 = mem[moff[11:0]];
    if (moff + 32'd1 < 32'd4096)  mb1 = mem[12'(moff + 32'd1)];
    if (moff + 32'd2 < 32'd4096)  mb2 = mem[12'(moff + 32'd2)];
    if (moff + 32'd3 < 32'd4096)  mb3 = mem[12'(moff + 32'd3)];
    case (mem_type)
      2'b00:   mem_rd = {mb3, mb2, mb1, mb0};
      2'b01:   mem_rd = {{24{mb0[7]}}, mb0};
      2'b10:   mem_rd = {{16{mb1[7]}}, mb1, mb0};
      default: mem_rd = 32'h0000_0000;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_clr_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem_clr_done <= 1'b1;
    end else if (mem_we) begin
      if (moff < 32'd4096) mem[moff[11:0]] <= mem_wd[7:0];
      if (mem_type != 2'b01 && moff + 32'd1 < 32'd4096) mem[12'(moff + 32'd1)] <= mem_wd[15:8];
      if (mem_type == 2'b00 && moff + 32'd3 < 32'd4096) begin
        mem[12'(moff + 32'd2)] <= mem_wd[23:16];
        mem[12'(moff + 32'd3)] <= mem_wd[31:24];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   grant_log[$];
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   we_last = -1;
  int   rv_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        we_last = cyc;
      end
      if (p0_rvalid && p1_rvalid) begin
        checks++;
        errors++;
        $display("FAIL dual_rvalid: both ports responded at cycle %0d", cyc);
      end else if (p0_rvalid || p1_rvalid) begin
        rv_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: p0=%b p1=%b with empty scoreboard at cycle %0d",
                   p0_rvalid, p1_rvalid, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_port", {31'd0, p1_rvalid}, 32'(e.port));
          chk("resp_err", {31'd0, (p1_rvalid ? p1_err : p0_err)}, {31'd0, e.err});
          chk("resp_rdata", p1_rvalid ? p1_rdata : p0_rdata, e.rdata);
          chk("resp_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic set_port(input int port, input logic v, input logic we, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] wd);
    if (port == 1) begin
      p1_valid = v; p1_we = we; p1_type = t; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_valid = v; p0_we = we; p0_type = t; p0_addr = a; p0_wdata = wd;
    end
  endtask

  task automatic do_req(input int port, input logic we, input logic [1:0] t,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic eerr, input logic [31:0] erd, output int hs_cyc);
    bit   done = 1'b0;
    logic rdy;
    exp_t e;
    hs_cyc = -1;
    @(negedge clk);
    set_port(port, 1'b1, we, t, a, wd);
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      rdy = (port == 1) ? p1_ready : p0_ready;
      if (rdy) begin
        hs_cyc  = cyc;
        e.port  = port;
        e.err   = eerr;
        e.rdata = erd;
        e.due   = cyc + (eerr ? 1 : 2);
        sbq.push_back(e);
        grant_log.push_back(port);
        done = 1'b1;
        @(posedge clk);
        #1;
        set_port(port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: port %0d never granted", port);
      set_port(port, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  logic [31:0] ill_addr [5] = '{32'h0000_1002, 32'h0000_1001, 32'h0000_1000,
                                32'h0000_0FFC, 32'h0000_1FFE};
  logic [1:0]  ill_type [5] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, we0, rv0;
    rst = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    p0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Word write then read back
    we0 = we_cnt;
    do_req(0, 1'b1, 2'b00, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0, h);
    drain();
    chk("write_we_count", 32'(we_cnt - we0), 32'd1);
    chk("write_we_cycle", 32'(we_last), 32'(h + 1));
    do_req(0, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF, h);
    drain();

    // Contended ports: grants must alternate starting with port 0
    grant_log.delete();
    fork
      begin : c0
        int hx;
        for (int i = 0; i < 4; i++)
          do_req(0, 1'b1, 2'b00, 32'(32'h0000_1100 + 4 * i), 32'(32'hA5A5_0000 + i), 1'b0, 32'h0, hx);
      end
      begin : c1
        int hy;
        for (int j = 0; j < 4; j++)
          do_req(1, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF, hy);
      end
    join
    drain();
    chk("rr_grant_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("rr_grant_order", 32'(grant_log[k]), 32'(k % 2));

    // Illegal requests: error one cycle after handshake, no memory write
    we0 = we_cnt;
    for (int i = 0; i < 5; i++)
      do_req(0, 1'b1, ill_type[i], ill_addr[i], 32'h1234_5678, 1'b1, 32'h0, h);
    drain();
    chk("illegal_no_we", 32'(we_cnt - we0), 32'd0);
    do_req(1, 1'b0, 2'b00, 32'h0000_1FFC, 32'h0, 1'b0, 32'h0, h);
    do_req(0, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 1'b0, 32'hDEAD_BEEF, h);
    drain();

    // Byte 0x80 at 0x1003, read by port 1 sign-extended
    do_req(0, 1'b1, 2'b01, 32'h0000_1003, 32'h0000_0080, 1'b0, 32'h0, h);
    do_req(1, 1'b0, 2'b01, 32'h0000_1003, 32'h0, 1'b0, 32'hFFFF_FF80, h);
    drain();

    // Reset during the ACCESS cycle of a port 1 read
    do_req(1, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 1'b0, 32'h80AD_BEEF, h);
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_type", {30'd0, mem_type}, 32'd0);
    chk("arst_mem_wd", mem_wd, 32'd0);
    chk("arst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("arst_p1_rdata", p1_rdata, 32'd0);
    sbq.delete();
    rv0 = rv_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_no_rvalid", 32'(rv_cnt - rv0), 32'd0);

    grant_log.delete();
    fork
      begin : r0
        int hx;
        do_req(0, 1'b0, 2'b00, 32'h0000_1100, 32'h0, 1'b0, 32'hA5A5_0000, hx);
      end
      begin : r1
        int hy;
        do_req(1, 1'b0, 2'b10, 32'h0000_1002, 32'h0, 1'b0, 32'hFFFF_80AD, hy);
      end
    join
    drain();
    chk("arst_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) chk("arst_ptr_first", 32'(grant_log[0]), 32'd0);
    else                      chk("arst_ptr_first", 32'hFFFF_FFFF, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug master).
- Accepts requests on valid/ready handshakes and round-robins between the two ports.
- Sequences one memory access per grant, drives the memory's WE, dataType, A and WD, and registers RD into a one-cycle response pulse.
- Rejects misaligned, out-of-range or illegal-type requests with an error response and never touches memory for them.

Parameters:
- ADDRESS_WIDTH, 32, width of request and memory address.
- DATA_WIDTH, 32, width of write and read data.
- MEM_BASE, 32'h0000_1000, lowest legal byte address.
- MEM_SIZE, 32'h0000_1000, legal window size in bytes. An access is legal only if all of its bytes lie in [MEM_BASE, MEM_BASE+MEM_SIZE).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_we  in  1  port 0 write (1) / read (0)
- p0_type  in  2  port 0 dataType: 00 word, 01 byte, 10 halfword, 11 illegal
- p0_addr  in  ADDRESS_WIDTH  port 0 byte address
- p0_wdata  in  DATA_WIDTH  port 0 write data
- p0_rvalid  out  1  port 0 response pulse
- p0_rdata  out  DATA_WIDTH  port 0 read data, sign-extended per type
- p0_err  out  1  port 0 error flag, qualified by p0_rvalid
- p1_*  same set as p0_* for port 1
- mem_we  out  1  memory write enable
- mem_type  out  2  memory dataType
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory combinational read data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer at port 0.
- Reset is asynchronous and takes effect mid-access. An in-flight access is dropped with no response; a write already committed on that edge stays committed.
- FSM states:
  - IDLE: ready is asserted to at most one port, chosen by the arbiter.
  - ACCESS: memory is driven for exactly one cycle.
  - RESP: response pulse.
- Arbitration in IDLE:
  - If only one port is valid, that port gets ready.
  - If both are valid, the port named by the pointer wins. The pointer then flips to the other port.
  - The pointer changes only on a grant to a contended pair.
  - Ready is combinational from valid and state.
  - A handshake (valid & ready) latches port id, we, type, addr and wdata into registers.
- Legality check on the latched request. The request is illegal if any of:
  - type is 11;
  - type is word and addr[1:0] != 0;
  - type is halfword and addr[0] != 0;
  - any byte of the access lies outside the window.
- Next state after handshake:
  - Legal: go to ACCESS.
  - Illegal: skip ACCESS and go directly to RESP with err=1, rdata=0, mem_we never asserted.
- ACCESS, one cycle:
  - mem_addr, mem_type, mem_wd come from the latched registers.
  - mem_we equals the latched we.
  - mem_rd is sampled into the rdata register at the end of the cycle.
  - Next state is RESP.
- Outside ACCESS, mem_we=0. mem_addr, mem_type and mem_wd hold their last values (no glitching required).
- RESP, one cycle:
  - The granted port's rvalid=1 and err reflects legality.
  - rdata holds the captured value for reads, or 0 for writes.
  - Next state is IDLE.
  - The other port's rvalid stays 0.
- Latency:
  - Handshake at cycle N, mem access at N+1, rvalid at N+2.
  - Error responses: handshake at N, rvalid at N+1.
  - Peak throughput is one access per 3 cycles.
- Sign extension is done by memory. The arbiter passes mem_rd unchanged.
- Requesters must hold valid and the payload until ready. Payload changes while not ready are ignored.
- A valid dropped before ready is not an error and is never served.
- Simultaneous new valid during RESP: not accepted until IDLE.

Decomposition:
- Shared package mem_pkg:
  - dataType enum (WORD=2'b00, BYTE=2'b01, HALF=2'b10);
  - arbiter state enum (IDLE, ACCESS, RESP);
  - MEM_BASE and MEM_SIZE defaults.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with pointer register, reused later for the instruction-fetch/loader split.

Test Plan:
- Port 0 word write 32'hDEADBEEF to 0x1000, then port 0 word read 0x1000. Required:
  - mem_we high exactly one cycle, 1 cycle after the write handshake.
  - Read rvalid 2 cycles after its handshake, rdata=32'hDEADBEEF, err=0.
- Both ports valid in the same cycle, repeatedly, 4 requests each. Required:
  - Grants alternate 0,1,0,1,... starting with port 0 after reset.
  - No port waits more than one other access.
- Port 1 byte read of 0x1003 holding 8'h80. Required: p1_rdata=32'hFFFFFF80, p1_rvalid only, p0_rvalid stays 0.
- Illegal requests each produce err=1 one cycle after handshake, with no mem_we and no change to memory:
  - word at 0x1002;
  - halfword at 0x1001;
  - type 11;
  - word at 0x0FFC;
  - word at 0x1FFE.
- Assert rst in the ACCESS cycle of a port 1 read. Required:
  - All outputs 0 immediately (asynchronous).
  - No rvalid afterwards, pointer back to port 0, FSM serves a fresh port 0 request normally.
